// File: rtl/cpeta.sv
// Carry-prediction error-tolerant approximate adder with a registered sum.
// Optional registered carry-out of the exact upper part: define CPETA_COUT_EN.
module cpeta #(
    parameter int unsigned n = 16,
    parameter int unsigned k = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    output logic [n-1:0] sum
`ifdef CPETA_COUT_EN
    ,
    output logic         cout
`endif
);

    generate
        if (k < 1 || k > n - 1) begin : g_bad_k
            $error("cpeta: k must satisfy 1 <= k <= n-1");
        end
    endgenerate

    logic [k-1:0] g;
    logic [k-1:0] p;
    logic [k-1:0] sat;
    logic [k-1:0] lo;
    logic         cpred;

    assign g     = A[k-1:0] & B[k-1:0];
    assign p     = A[k-1:0] ^ B[k-1:0];
    assign cpred = g[k-1];

    // sat[i] is set once any bit at or above i has both operands at one.
    always_comb begin
        sat      = '0;
        sat[k-1] = g[k-1];
        for (int unsigned i = 1; i < k; i++) begin
            sat[k-1-i] = sat[k-i] | g[k-1-i];
        end
    end

    assign lo = p | sat;

`ifdef CPETA_COUT_EN
    logic [n-k:0] hi;

    assign hi = (n-k+1)'(A[n-1:k]) + (n-k+1)'(B[n-1:k]) + (n-k+1)'(cpred);

    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= {hi[n-k-1:0], lo};
            cout <= hi[n-k];
        end
    end
`else
    logic [n-k-1:0] hi;

    assign hi = A[n-1:k] + B[n-1:k] + (n-k)'(cpred);

    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= '0;
        end else begin
            sum <= {hi, lo};
        end
    end
`endif

endmodule

// File: tb/tb_cpeta.sv
// Self-checking bench for cpeta (n=16, k=6): directed vector table plus
// randomized stimulus against a behavioural model.
module tb_cpeta;

    localparam int N = 16;
    localparam int K = 6;

    logic          clk;
    logic          rst;
    logic [N-1:0]  A;
    logic [N-1:0]  B;
    logic [N-1:0]  sum;
`ifdef CPETA_COUT_EN
    logic          cout;
`endif

    int passed;
    int total;

    cpeta #(.n(N), .k(K)) dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .sum (sum)
`ifdef CPETA_COUT_EN
        ,
        .cout(cout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          r;
        logic [N-1:0]  a;
        logic [N-1:0]  b;
        logic [N-1:0]  s;
        logic          c;
    } vec_t;

    // Reference: scan the low part for the first both-one bit from the top,
    // add the upper fields as integers and split quotient/remainder.
    function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] lo;
        bit           seen;
        int           hi;
        int           cp;
        lo   = '0;
        seen = 0;
        for (int i = K - 1; i >= 0; i--) begin
            if (a[i] && b[i]) seen = 1;
            lo[i] = seen ? 1'b1 : (a[i] ^ b[i]);
        end
        cp = (a[K-1] && b[K-1]) ? 1 : 0;
        hi = int'(a >> K) + int'(b >> K) + cp;
        return {(hi >= (1 << (N - K))) ? 1'b1 : 1'b0,
                N'((hi % (1 << (N - K))) << K) | lo};
    endfunction

    task automatic check(input string name, input logic [N-1:0] got_s, input logic [N-1:0] exp_s,
                         input logic got_c, input logic exp_c);
        total++;
        if (got_s === exp_s) passed++;
        else $display("FAIL %s sum: got %h expected %h", name, got_s, exp_s);
`ifdef CPETA_COUT_EN
        total++;
        if (got_c === exp_c) passed++;
        else $display("FAIL %s cout: got %b expected %b", name, got_c, exp_c);
`endif
    endtask

    function automatic logic get_cout();
`ifdef CPETA_COUT_EN
        return cout;
`else
        return 1'b0;
`endif
    endfunction

    vec_t tbl[$];

    initial begin
        vec_t         v;
        logic [N:0]   m;
        logic [N-1:0] exp_s;
        logic         exp_c;
        logic         r;
        passed = 0;
        total  = 0;
        rst = 1'b1;
        A   = '0;
        B   = '0;

        tbl.push_back('{1'b1, 16'h1234, 16'h5678, 16'h0000, 1'b0});
        tbl.push_back('{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0});
        tbl.push_back('{1'b0, 16'h1234, 16'h5678, 16'h68BF, 1'b0});
        tbl.push_back('{1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0});
        tbl.push_back('{1'b0, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0});
        tbl.push_back('{1'b0, 16'h0F0F, 16'hF0F0, 16'hFFFF, 1'b0});
        tbl.push_back('{1'b0, 16'hFFC0, 16'h0060, 16'h0020, 1'b1});
        tbl.push_back('{1'b0, 16'h1234, 16'h5678, 16'h68BF, 1'b0});
        tbl.push_back('{1'b0, 16'h0020, 16'h0020, 16'h007F, 1'b0});
        tbl.push_back('{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1});
        tbl.push_back('{1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0});
        tbl.push_back('{1'b0, 16'h0001, 16'h0001, 16'h0001, 1'b0});
        tbl.push_back('{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1});

        // Back-to-back: one new vector per cycle, each result checked one cycle later.
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            if (i > 0) begin
                v = tbl[i-1];
                check($sformatf("vec%0d", i - 1), sum, v.s, get_cout(), v.c);
            end
            rst = tbl[i].r;
            A   = tbl[i].a;
            B   = tbl[i].b;
        end
        @(negedge clk);
        v = tbl[tbl.size()-1];
        check($sformatf("vec%0d", tbl.size() - 1), sum, v.s, get_cout(), v.c);

        // Reset held for several cycles with live operands, then release.
        rst = 1'b1;
        A   = 16'h1234;
        B   = 16'h5678;
        repeat (3) begin
            @(negedge clk);
            check("rst_hold", sum, 16'h0000, get_cout(), 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("rst_release", sum, 16'h68BF, get_cout(), 1'b0);

        // Randomized stimulus with occasional reset against the model.
        exp_s = 16'h68BF;
        exp_c = 1'b0;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 15) == 0);
            rst = r;
            A   = N'($urandom);
            B   = N'($urandom);
            if ($urandom_range(0, 7) == 0) B = A;
            if ($urandom_range(0, 7) == 0) A = ~B;
            m = model(A, B);
            exp_s = r ? '0 : m[N-1:0];
            exp_c = r ? 1'b0 : m[N];
            @(negedge clk);
            check($sformatf("rand%0d", i), sum, exp_s, get_cout(), exp_c);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
